// File: rtl/md4_padder.sv
// MD4 message padder: packs a byte stream into 512-bit little-endian blocks,
// appends the 0x80 terminator, zero fill and 64-bit bit length.
module md4_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, EMIT, TAIL} state_t;

    state_t           state, state_next;
    logic [7:0]       bytes [64];
    logic [6:0]       idx, fidx;
    logic [LEN_W-1:0] len, len_next;
    logic [63:0]      len_cur64, len_new64;
    logic             first_pend, tail_pending, tail_marker;
    logic             first_q, last_q;
    logic             accept;

    assign in_ready  = (state == FILL) && reset;
    assign blk_valid = (state == EMIT);
    assign blk_first = first_q & blk_valid;
    assign blk_last  = last_q & blk_valid;
    assign accept    = in_valid & in_ready;
    assign fidx      = idx + 7'(in_keep);
    assign len_next  = in_keep ? len + LEN_W'(8) : len;
    assign len_cur64 = 64'(len);
    assign len_new64 = 64'(len_next);

    always_comb begin
        blk_data = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            blk_data[480 - 32 * (i >> 2) + 8 * (i & 3) +: 8] = bytes[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (accept && (in_last || fidx == 7'd64)) state_next = EMIT;
            EMIT: if (blk_ready) state_next = tail_pending ? TAIL : FILL;
            TAIL: state_next = EMIT;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx          <= '0;
            len          <= '0;
            first_pend   <= 1'b1;
            tail_pending <= 1'b0;
            tail_marker  <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            for (int unsigned i = 0; i < 64; i++) bytes[i] <= '0;
        end else begin
            case (state)
                FILL: if (accept) begin
                    idx <= fidx;
                    len <= len_next;
                    if (in_keep) bytes[idx[5:0]] <= in_data;
                    if (in_last || fidx == 7'd64) begin
                        first_q    <= first_pend;
                        first_pend <= 1'b0;
                        last_q     <= in_last && (fidx <= 7'd55);
                    end
                    if (in_last) begin
                        if (fidx != 7'd64) bytes[fidx[5:0]] <= 8'h80;
                        if (fidx <= 7'd55) begin
                            for (int unsigned k = 0; k < 8; k++) bytes[56 + k] <= len_new64[8 * k +: 8];
                        end else begin
                            tail_pending <= 1'b1;
                            tail_marker  <= (fidx == 7'd64);
                        end
                    end
                end
                EMIT: if (blk_ready && !tail_pending) begin
                    // Clearing here keeps every unwritten byte of the next block zero.
                    idx <= '0;
                    for (int unsigned i = 0; i < 64; i++) bytes[i] <= '0;
                    if (last_q) begin
                        len        <= '0;
                        first_pend <= 1'b1;
                    end
                end
                TAIL: begin
                    for (int unsigned i = 0; i < 64; i++) bytes[i] <= '0;
                    bytes[0] <= tail_marker ? 8'h80 : 8'h00;
                    for (int unsigned k = 0; k < 8; k++) bytes[56 + k] <= len_cur64[8 * k +: 8];
                    tail_pending <= 1'b0;
                    tail_marker  <= 1'b0;
                    first_q      <= 1'b0;
                    last_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md4_padder.sv
// Bench for md4_padder: directed vector table with hand-derived blocks, plus
// randomized messages checked against a padding model built on byte queues.
module tb_md4_padder;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_keep, in_last;
    logic         blk_valid, blk_ready, blk_first, blk_last;
    logic [7:0]   in_data;
    logic [511:0] blk_data;

    always #5 clk = ~clk;

    md4_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last)
    );

    typedef struct { logic [7:0] d; logic k; logic l; } beat_t;
    typedef struct { logic [511:0] d; logic f; logic l; } blk_t;
    typedef struct {
        string s; int n_fill; logic [7:0] fill; bit empty_last; int mode; int nblk;
        logic [511:0] b0; logic [511:0] b1;
    } vec_t;

    beat_t beats[$];
    blk_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    vec_t  tbl[7];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic queue_msg(input logic [7:0] m[$], input bit empty_last);
        if (m.size() == 0) beats.push_back('{d: 8'h00, k: 1'b0, l: 1'b1});
        else begin
            for (int i = 0; i < m.size(); i++)
                beats.push_back('{d: m[i], k: 1'b1, l: (i == m.size() - 1) && !empty_last});
            if (empty_last) beats.push_back('{d: 8'h00, k: 1'b0, l: 1'b1});
        end
    endtask

    // Reference: classic pad-then-split over a byte queue.
    function automatic void model(input logic [7:0] m[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] v;
        logic [31:0]  w;
        int           nb;
        p = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 0; k < 8; k++) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            v = '0;
            for (int wi = 0; wi < 16; wi++) begin
                w = {p[64*b+4*wi+3], p[64*b+4*wi+2], p[64*b+4*wi+1], p[64*b+4*wi]};
                v = {v[479:0], w};
            end
            exp_q.push_back('{d: v, f: (b == 0), l: (b == nb - 1)});
        end
    endfunction

    // mode 0: always ready; 1: random valid/ready; 2: 5-cycle stall per block; 3: never ready
    task automatic run(input int mode);
        int           cyc, budget, stall_n, tail_ph;
        bit           lat_pend, msg_done, prev_stall;
        logic [511:0] held_d;
        logic         held_f, held_l;
        beat_t        b;
        blk_t         e;
        cyc = 0; stall_n = 0; tail_ph = 0;
        lat_pend = 0; msg_done = 0; prev_stall = 0;
        budget = 400 + 30 * beats.size();
        while ((beats.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (lat_pend) begin chk1("blk_valid_latency", blk_valid, 1'b1); lat_pend = 0; end
            if (tail_ph == 2) begin chk1("tail_valid_latency", blk_valid, 1'b1); tail_ph = 0; end
            if (tail_ph == 1) begin chk1("tail_gap", blk_valid, 1'b0); tail_ph = 2; end
            if (prev_stall) begin
                chk1("stall_valid", blk_valid, 1'b1);
                check("stall_data", blk_data, held_d);
                chk1("stall_first", blk_first, held_f);
                chk1("stall_last", blk_last, held_l);
                chk1("stall_in_ready", in_ready, 1'b0);
            end
            case (mode)
                0: blk_ready = 1'b1;
                1: blk_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    blk_ready = blk_valid && (stall_n >= 5);
                    if (blk_valid && stall_n < 5) stall_n++;
                end
                default: blk_ready = 1'b0;
            endcase
            in_valid = (beats.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            if (beats.size() > 0) begin
                in_data = beats[0].d; in_keep = beats[0].k; in_last = beats[0].l;
            end else begin
                in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
            end
            prev_stall = blk_valid && !blk_ready;
            held_d = blk_data; held_f = blk_first; held_l = blk_last;
            if (in_valid && in_ready) begin
                b = beats.pop_front();
                if (b.l) begin lat_pend = 1; msg_done = 1; end
            end
            if (blk_valid && blk_ready) begin
                stall_n = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_block actual=%h required=none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.d);
                    chk1("blk_first", blk_first, e.f);
                    chk1("blk_last", blk_last, e.l);
                    if (msg_done && !e.l) tail_ph = 1;
                    if (e.l) msg_done = 0;
                end
            end
        end
        if (cyc >= budget) begin
            checks++; errors++;
            $display("FAIL timeout actual=%0d_cycles required=completion (beats %0d, blocks %0d left)",
                     cyc, beats.size(), exp_q.size());
            beats.delete(); exp_q.delete();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; blk_ready = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        check("rst_blk_data", blk_data, '0);
        chk1("rst_blk_first", blk_first, 1'b0);
        chk1("rst_blk_last", blk_last, 1'b0);
    endtask

    task automatic send_abc_after_reset();
        logic [7:0] m[$];
        m = '{8'h61, 8'h62, 8'h63};
        queue_msg(m, 0);
        exp_q.push_back('{d: {32'h80636261, 416'h0, 32'h00000018, 32'h0}, f: 1'b1, l: 1'b1});
        run(0);
    endtask

    initial begin
        logic [7:0] m[$];
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        tbl[0] = '{s: "", n_fill: 0, fill: 8'h00, empty_last: 0, mode: 0, nblk: 1,
                   b0: {32'h00000080, 480'h0}, b1: '0};
        tbl[1] = '{s: "abc", n_fill: 0, fill: 8'h00, empty_last: 0, mode: 0, nblk: 1,
                   b0: {32'h80636261, 416'h0, 32'h00000018, 32'h0}, b1: '0};
        tbl[2] = '{s: "abcdefghijklmnopqrstuvwxyz", n_fill: 0, fill: 8'h00, empty_last: 0, mode: 0, nblk: 1,
                   b0: {32'h64636261, 32'h68676665, 32'h6c6b6a69, 32'h706f6e6d, 32'h74737271,
                        32'h78777675, 32'h00807a79, 224'h0, 32'h000000d0, 32'h0}, b1: '0};
        tbl[3] = '{s: "", n_fill: 56, fill: 8'h61, empty_last: 0, mode: 0, nblk: 2,
                   b0: {{14{32'h61616161}}, 32'h00000080, 32'h0},
                   b1: {448'h0, 32'h000001c0, 32'h0}};
        tbl[4] = '{s: "", n_fill: 64, fill: 8'h00, empty_last: 0, mode: 2, nblk: 2,
                   b0: '0, b1: {32'h00000080, 416'h0, 32'h00000200, 32'h0}};
        tbl[5] = '{s: "", n_fill: 55, fill: 8'h62, empty_last: 0, mode: 0, nblk: 1,
                   b0: {{13{32'h62626262}}, 32'h80626262, 32'h000001b8, 32'h0}, b1: '0};
        tbl[6] = '{s: "abc", n_fill: 0, fill: 8'h00, empty_last: 1, mode: 0, nblk: 1,
                   b0: {32'h80636261, 416'h0, 32'h00000018, 32'h0}, b1: '0};

        for (int t = 0; t < 7; t++) begin
            m.delete();
            for (int i = 0; i < tbl[t].s.len(); i++) m.push_back(tbl[t].s[i]);
            for (int i = 0; i < tbl[t].n_fill; i++) m.push_back(tbl[t].fill);
            queue_msg(m, tbl[t].empty_last);
            if (tbl[t].nblk == 1) exp_q.push_back('{d: tbl[t].b0, f: 1'b1, l: 1'b1});
            else begin
                exp_q.push_back('{d: tbl[t].b0, f: 1'b1, l: 1'b0});
                exp_q.push_back('{d: tbl[t].b1, f: 1'b0, l: 1'b1});
            end
            run(tbl[t].mode);
        end

        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 5; n++) begin
                int len;
                m.delete();
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(52, 68) : $urandom_range(0, 140);
                for (int i = 0; i < len; i++) m.push_back(8'($urandom));
                queue_msg(m, $urandom_range(0, 3) == 0);
                model(m);
            end
            run(1);
        end

        m.delete();
        for (int i = 0; i < 30; i++) m.push_back(8'h78);
        for (int i = 0; i < m.size(); i++) beats.push_back('{d: m[i], k: 1'b1, l: 1'b0});
        run(0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        send_abc_after_reset();

        for (int i = 0; i < 64; i++) beats.push_back('{d: 8'h5a, k: 1'b1, l: 1'b0});
        run(3);
        @(negedge clk);
        chk1("emit_before_reset", blk_valid, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        send_abc_after_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md4_padder.md
Name: md4_padder

Overview:
- Upstream stage of MD4. Accepts a message as a byte stream and emits MD4-padded 512-bit blocks.
- Output block format is exactly what the MD4 core's message input expects:
  - word0 in bits [511:480], words little-endian;
  - 0x80 terminator and zero fill;
  - 64-bit bit length in words 14/15.
- Handles messages of any length, including empty. Emits 1 to N blocks with first/last flags so the core can load the IV and finalize.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Length is taken mod 2^LEN_W and zero-extended to 64 bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  byte beat valid.
- in_ready  output  1  padder can accept a beat this cycle.
- in_data  input  8  message byte.
- in_keep  input  1  1: in_data is a message byte; 0: no byte. in_keep=0 is legal only with in_last=1.
- in_last  input  1  beat ends the message.
- blk_valid  output  1  blk_data holds a complete block.
- blk_ready  input  1  consumer takes the block.
- blk_data  output  512  padded block.
- blk_first  output  1  block is the message's first.
- blk_last  output  1  block is the message's final (padded) block.

Behaviour:
- Beat accepted when in_valid & in_ready. Block transferred when blk_valid & blk_ready.
- Byte i (0..63) of a block lands in word w=i/4 at lane b=i%4, i.e. bits [480-32w+8b +: 8].
  - Example: "abcd" gives word0=0x64636261.
- Bit length L = 8 × total byte count, counted mod 2^LEN_W. Low 32 bits go to word14 (bits [63:32]), high 32 bits to word15 (bits [31:0]).
- States:
  - FILL: in_ready=1; write byte at idx, then idx++.
  - EMIT: in_ready=0; blk_valid=1; hold blk_data until blk_ready.
  - TAIL: build the extra length-only block.
- FILL transitions:
  - Non-last byte making idx reach 64: go to EMIT, blk_last=0.
  - Last beat with final idx ≤ 55: same cycle, 0x80 at idx, zeros to byte 55, length at 56..63. Go to EMIT, blk_last=1.
  - Last beat with final idx in 56..63: 0x80 at idx, zeros to 63. Go to EMIT, blk_last=0, tail_pending=1.
  - Last beat with final idx = 64: go to EMIT, blk_last=0, tail_pending=1, tail_marker=1.
- EMIT on transfer:
  - If tail_pending: go to TAIL.
  - Else: go to FILL; clear idx; if blk_last, clear length and set the first flag.
- TAIL (one cycle): block = zeros, 0x80 at byte 0 iff tail_marker, length at 56..63. Go to EMIT with blk_last=1.
- Latency: blk_valid rises on the clock edge after the accepting edge of the 64th or last beat. Tail block blk_valid rises 2 cycles after the prior block transfer.
- blk_first is 1 on the first block after reset or after a blk_last transfer, else 0.
- Backpressure: while blk_valid & !blk_ready, blk_data, blk_first and blk_last are stable and in_ready=0.
- Length counter wraps silently mod 2^LEN_W; no error flag.
- Reset (reset=0 at an edge), including mid-message or mid-EMIT:
  - state=FILL, idx=0, length=0, first=1, tail flags=0;
  - blk_valid=0, blk_first=0, blk_last=0, blk_data=0;
  - in_ready=0 while reset is low; partial data discarded.
- Unused buffer bytes are zero by construction (buffer cleared on every EMIT exit to FILL).

Test Plan:
- Empty message (one beat: in_keep=0, in_last=1) -> one block:
  - word0=0x00000080, words1..15=0;
  - blk_first=1, blk_last=1.
- "abc" -> one block:
  - word0=0x80636261, word14=0x00000018, all other words 0;
  - blk_valid one cycle after the last beat.
- "a".."z" (26 bytes) -> one block =
  - 0x64636261_68676665_6c6b6a69_706f6e6d_74737271_78777675_00807a79, then words 7..13 zero, word14=0x000000d0, word15=0.
- 56-byte message -> two blocks:
  - first has 0x80 at byte 56, blk_last=0;
  - second is all zero except word14=0x000001c0, blk_first=0, blk_last=1.
- 64 bytes of 0x00, blk_ready held low 5 cycles on each block -> two blocks:
  - data stable during the stall; in_ready=0 throughout the stall;
  - second block word0=0x00000080, word14=0x00000200.
- Reset after 30 bytes, then "abc" -> only the "abc" block appears, with blk_first=1.
